// File: rtl/panda_lut_seq.sv
// panda_lut_seq
// Table-driven FUNC sequencer for a panda_lut instance. A register-file table
// of {FUNC, dwell} entries is stepped through once enabled, each FUNC being
// presented for its dwell time. After the programmed number of table passes
// the output falls back to a static idle FUNC.
//
// Ports:
//   clk_i         system clock, rising edge
//   reset_i       asynchronous active-low reset
//   enable_i      rising edge starts a sequence, low aborts it
//   TABLE_LENGTH  number of valid entries (clamped to DEPTH, 0 = no run)
//   REPEATS       number of table passes (0 = run forever)
//   IDLE_FUNC     FUNC driven while not running
//   tbl_wr_i      table write strobe (accepted only while idle)
//   tbl_addr_i    table write address
//   tbl_func_i    FUNC field to write
//   tbl_dwell_i   dwell field to write, in clocks (0 behaves as 1)
//   func_o        FUNC to panda_lut
//   func_upd_o    one-cycle pulse on every table-step load of func_o
//   index_o       current entry index
//   active_o      high while running
//   done_o        one-cycle pulse on normal completion
//   wr_err_o      sticky: a table write was attempted while running
module panda_lut_seq #(
  parameter int DEPTH = 16,
  parameter int CW    = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          enable_i,
  input  logic [AW:0]   TABLE_LENGTH,
  input  logic [31:0]   REPEATS,
  input  logic [31:0]   IDLE_FUNC,
  input  logic          tbl_wr_i,
  input  logic [AW-1:0] tbl_addr_i,
  input  logic [31:0]   tbl_func_i,
  input  logic [CW-1:0] tbl_dwell_i,
  output logic [31:0]   func_o,
  output logic          func_upd_o,
  output logic [AW-1:0] index_o,
  output logic          active_o,
  output logic          done_o,
  output logic          wr_err_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        state_q;
  logic [31:0]   func_mem_q  [DEPTH];
  logic [CW-1:0] dwell_mem_q [DEPTH];

  logic          en_q;
  logic          armed_q;     // set once enable_i has been seen low after reset
  logic [AW:0]   len_q;
  logic [31:0]   rep_q;
  logic [31:0]   pass_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   func_q;
  logic          func_upd_q;
  logic          active_q;
  logic          done_q;
  logic          wr_err_q;

  logic          start_s;
  logic [AW:0]   len_eff_s;
  logic [CW-1:0] dwell_eff_s;
  logic          expire_s;
  logic          last_s;
  logic          pass_end_s;
  logic [AW-1:0] idx_nxt_s;
  logic [31:0]   pass_nxt_s;

  // Start detect, length clamp and dwell expiry decode.
  always_comb begin
    start_s     = enable_i & ~en_q & armed_q;
    len_eff_s   = TABLE_LENGTH;
    dwell_eff_s = dwell_mem_q[idx_q];
    if (TABLE_LENGTH > (AW+1)'(DEPTH)) begin
      len_eff_s = (AW+1)'(DEPTH);
    end else begin
      len_eff_s = TABLE_LENGTH;
    end
    // A zero dwell holds the entry for one cycle, same as a dwell of 1.
    if (dwell_mem_q[idx_q] == {CW{1'b0}}) begin
      dwell_eff_s = CW'(1);
    end else begin
      dwell_eff_s = dwell_mem_q[idx_q];
    end
    expire_s   = (cnt_q >= dwell_eff_s);
    last_s     = ({1'b0, idx_q} == (len_q - (AW+1)'(1)));
    idx_nxt_s  = idx_q + AW'(1);
    pass_nxt_s = pass_q + 32'd1;
    pass_end_s = (rep_q != 32'd0) && (pass_nxt_s == rep_q);
  end

  // Table register file: cleared by reset, writable only while idle.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        func_mem_q[i]  <= 32'd0;
        dwell_mem_q[i] <= {CW{1'b0}};
      end
    end else if (tbl_wr_i && (state_q == ST_IDLE)) begin
      func_mem_q[tbl_addr_i]  <= tbl_func_i;
      dwell_mem_q[tbl_addr_i] <= tbl_dwell_i;
    end
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= ST_IDLE;
      en_q       <= 1'b0;
      armed_q    <= 1'b0;
      len_q      <= '0;
      rep_q      <= 32'd0;
      pass_q     <= 32'd0;
      cnt_q      <= {CW{1'b0}};
      idx_q      <= '0;
      func_q     <= 32'd0;
      func_upd_q <= 1'b0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      en_q       <= enable_i;
      func_upd_q <= 1'b0;
      done_q     <= 1'b0;
      if (!enable_i) begin
        armed_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          func_q   <= IDLE_FUNC;
          active_q <= 1'b0;
          idx_q    <= '0;
          // A start with zero effective length is silently ignored.
          if (start_s && (len_eff_s != '0)) begin
            state_q    <= ST_RUN;
            active_q   <= 1'b1;
            func_q     <= func_mem_q[0];
            func_upd_q <= 1'b1;
            cnt_q      <= CW'(1);
            pass_q     <= 32'd0;
            len_q      <= len_eff_s;
            rep_q      <= REPEATS;
            wr_err_q   <= 1'b0;
          end
        end
        ST_RUN: begin
          if (tbl_wr_i) begin
            wr_err_q <= 1'b1;
          end
          // Abort takes priority over a coincident dwell expiry.
          if (!enable_i) begin
            state_q  <= ST_IDLE;
            active_q <= 1'b0;
            func_q   <= IDLE_FUNC;
            idx_q    <= '0;
          end else if (expire_s) begin
            cnt_q <= CW'(1);
            if (!last_s) begin
              idx_q      <= idx_nxt_s;
              func_q     <= func_mem_q[idx_nxt_s];
              func_upd_q <= 1'b1;
            end else if (pass_end_s) begin
              pass_q   <= pass_nxt_s;
              state_q  <= ST_IDLE;
              active_q <= 1'b0;
              func_q   <= IDLE_FUNC;
              idx_q    <= '0;
              done_q   <= 1'b1;
            end else begin
              pass_q     <= pass_nxt_s;
              idx_q      <= '0;
              func_q     <= func_mem_q[0];
              func_upd_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          active_q <= 1'b0;
          func_q   <= IDLE_FUNC;
          idx_q    <= '0;
        end
      endcase
    end
  end

  assign func_o     = func_q;
  assign func_upd_o = func_upd_q;
  assign index_o    = idx_q;
  assign active_o   = active_q;
  assign done_o     = done_q;
  assign wr_err_o   = wr_err_q;

endmodule
